// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, commit and exception signals of the reorder buffer.
// The master side is the pipeline and the slave side is the ROB.
interface reorder_buffer_if #(
  parameter int DISPATCH_WIDTH       = 2,
  parameter int ROB_DEPTH            = 16,
  parameter int PHYS_REGS_ADDR_WIDTH = 6
) ();
  localparam int ROB_ADDR_WIDTH      = $clog2(ROB_DEPTH);
  localparam int DISPATCH_ADDR_WIDTH = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] dispatch_phys_rd;
  logic [DISPATCH_WIDTH-1:0][4:0]                      dispatch_arch_rd;
  logic [DISPATCH_WIDTH-1:0]                           dispatch_en;
  logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]  dispatch_bank_addr;
  logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       dispatch_rob_addr;
  logic                                                dispatch_full;

  logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]  writeback_bank_addr;
  logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       writeback_rob_addr;
  logic [DISPATCH_WIDTH-1:0]                           writeback_en;
  logic [DISPATCH_WIDTH-1:0]                           writeback_exc;

  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd;
  logic [DISPATCH_WIDTH-1:0][4:0]                      commit_arch_rd;
  logic [DISPATCH_WIDTH-1:0]                           commit_en;

  logic                                                exc_valid;
  logic [ROB_ADDR_WIDTH-1:0]                           exc_rob_addr;
  logic [DISPATCH_ADDR_WIDTH-1:0]                      exc_bank_addr;

  logic                                                flush;
  logic [ROB_ADDR_WIDTH:0]                             occupancy;

  modport master (
    output dispatch_phys_rd, dispatch_arch_rd, dispatch_en,
    input  dispatch_bank_addr, dispatch_rob_addr, dispatch_full,
    output writeback_bank_addr, writeback_rob_addr, writeback_en, writeback_exc,
    input  commit_phys_rd, commit_arch_rd, commit_en,
    input  exc_valid, exc_rob_addr, exc_bank_addr,
    output flush,
    input  occupancy
  );

  modport slave (
    input  dispatch_phys_rd, dispatch_arch_rd, dispatch_en,
    output dispatch_bank_addr, dispatch_rob_addr, dispatch_full,
    input  writeback_bank_addr, writeback_rob_addr, writeback_en, writeback_exc,
    output commit_phys_rd, commit_arch_rd, commit_en,
    output exc_valid, exc_rob_addr, exc_bank_addr,
    input  flush,
    output occupancy
  );
endinterface

// File: rtl/reorder_buffer.sv
// Row-based reorder buffer: one row per dispatch group, in-order retirement of
// the head row, precise exception at the lowest faulting bank, flush clears all.
module reorder_buffer #(
  parameter int DISPATCH_WIDTH       = 2,
  parameter int ROB_DEPTH            = 16,
  parameter int PHYS_REGS_ADDR_WIDTH = 6
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);
  localparam int DW  = DISPATCH_WIDTH;
  localparam int PW  = PHYS_REGS_ADDR_WIDTH;
  localparam int AW  = $clog2(ROB_DEPTH);
  localparam int DAW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(ROB_DEPTH);

  logic [DW-1:0]          valid_q [ROB_DEPTH];
  logic [DW-1:0]          valid_d [ROB_DEPTH];
  logic [DW-1:0]          done_q  [ROB_DEPTH];
  logic [DW-1:0]          done_d  [ROB_DEPTH];
  logic [DW-1:0]          exc_q   [ROB_DEPTH];
  logic [DW-1:0]          exc_d   [ROB_DEPTH];
  logic [DW-1:0][PW-1:0]  phys_q  [ROB_DEPTH];
  logic [DW-1:0][PW-1:0]  phys_d  [ROB_DEPTH];
  logic [DW-1:0][4:0]     arch_q  [ROB_DEPTH];
  logic [DW-1:0][4:0]     arch_d  [ROB_DEPTH];
  logic [AW-1:0]          head_q, head_d;
  logic [AW-1:0]          tail_q, tail_d;
  logic [AW:0]            count_q, count_d;

  logic                   head_ready;
  logic                   exc_hit;
  logic [DAW-1:0]         exc_idx;
  logic                   full;
  logic                   commit_fire;
  logic                   exc_fire;
  logic                   dispatch_fire;

  always_comb begin : head_eval
    head_ready = (count_q != '0);
    exc_hit    = 1'b0;
    exc_idx    = '0;
    for (int i = 0; i < DW; i++) begin
      if (valid_q[head_q][i] && !done_q[head_q][i]) head_ready = 1'b0;
      if (valid_q[head_q][i] && exc_q[head_q][i] && !exc_hit) begin
        exc_hit = 1'b1;
        exc_idx = DAW'(i);
      end
    end
  end

  // Full comes only from the registered count, so a same-cycle commit never frees a row.
  assign full          = (count_q == FULL_CNT);
  assign commit_fire   = head_ready && !exc_hit && !bus.flush && !rst;
  assign exc_fire      = head_ready && exc_hit && !bus.flush && !rst;
  assign dispatch_fire = (|bus.dispatch_en) && !full && !bus.flush;

  always_comb begin : outputs
    for (int i = 0; i < DW; i++) begin
      bus.dispatch_rob_addr[i]  = tail_q;
      bus.dispatch_bank_addr[i] = DAW'(i);
      bus.commit_en[i]          = valid_q[head_q][i] &&
                                  (commit_fire || (exc_fire && (DAW'(i) < exc_idx)));
      bus.commit_phys_rd[i]     = phys_q[head_q][i];
      bus.commit_arch_rd[i]     = arch_q[head_q][i];
    end
    bus.exc_valid     = exc_fire;
    bus.exc_rob_addr  = head_q;
    bus.exc_bank_addr = exc_idx;
    bus.dispatch_full = full;
    bus.occupancy     = count_q;
  end

  always_comb begin : next_state
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    phys_d  = phys_q;
    arch_d  = arch_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Ports hitting the same slot simply OR their done/exc effects.
    for (int k = 0; k < DW; k++) begin
      if (bus.writeback_en[k]) begin
        for (int i = 0; i < DW; i++) begin
          if ((bus.writeback_bank_addr[k] == DAW'(i)) &&
              valid_q[bus.writeback_rob_addr[k]][i]) begin
            done_d[bus.writeback_rob_addr[k]][i] = 1'b1;
            if (bus.writeback_exc[k]) exc_d[bus.writeback_rob_addr[k]][i] = 1'b1;
          end
        end
      end
    end

    if (dispatch_fire) begin
      valid_d[tail_q] = bus.dispatch_en;
      done_d[tail_q]  = '0;
      exc_d[tail_q]   = '0;
      phys_d[tail_q]  = bus.dispatch_phys_rd;
      arch_d[tail_q]  = bus.dispatch_arch_rd;
      tail_d          = tail_q + AW'(1);
    end

    if (commit_fire) begin
      valid_d[head_q] = '0;
      head_d          = head_q + AW'(1);
    end

    count_d = count_q + (AW+1)'(dispatch_fire) - (AW+1)'(commit_fire);

    if (bus.flush || exc_fire) begin
      for (int r = 0; r < ROB_DEPTH; r++) begin
        valid_d[r] = '0;
        done_d[r]  = '0;
        exc_d[r]   = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '{default: '0};
      done_q  <= '{default: '0};
      exc_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is only observed behind a valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    phys_q <= phys_d;
    arch_q <= arch_d;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table plus hand-written
// sequences for fill/wrap and mid-operation reset.
module tb_reorder_buffer;
  localparam int DW = 2;
  localparam int DEPTH = 16;
  localparam int PW = 6;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  reorder_buffer_if #(.DISPATCH_WIDTH(DW), .ROB_DEPTH(DEPTH), .PHYS_REGS_ADDR_WIDTH(PW)) bus ();

  reorder_buffer #(.DISPATCH_WIDTH(DW), .ROB_DEPTH(DEPTH), .PHYS_REGS_ADDR_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] d_en;
    logic [5:0] d_p0, d_p1;
    logic [4:0] d_a0, d_a1;
    logic [1:0] wb_en;
    logic [3:0] wb_r0, wb_r1;
    logic       wb_b0, wb_b1;
    logic [1:0] wb_exc;
    logic       fl;
    logic [1:0] e_ce;
    logic [5:0] e_p0, e_p1;
    logic [4:0] e_a0, e_a1;
    logic       e_ex;
    logic       e_exb;
    logic [3:0] e_exr;
    logic [4:0] e_occ;
    logic [3:0] e_tail;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int d_en, p0, p1, a0, a1,
                             input int wen, r0, b0, r1, b1, wexc, fl,
                             input int ce, cp0, cp1, ca0, ca1, ex, exb, exr, occ, tail);
    vec_t t;
    t.d_en = d_en[1:0]; t.d_p0 = p0[5:0]; t.d_p1 = p1[5:0]; t.d_a0 = a0[4:0]; t.d_a1 = a1[4:0];
    t.wb_en = wen[1:0]; t.wb_r0 = r0[3:0]; t.wb_b0 = b0[0]; t.wb_r1 = r1[3:0]; t.wb_b1 = b1[0];
    t.wb_exc = wexc[1:0]; t.fl = fl[0];
    t.e_ce = ce[1:0]; t.e_p0 = cp0[5:0]; t.e_p1 = cp1[5:0]; t.e_a0 = ca0[4:0]; t.e_a1 = ca1[4:0];
    t.e_ex = ex[0]; t.e_exb = exb[0]; t.e_exr = exr[3:0]; t.e_occ = occ[4:0]; t.e_tail = tail[3:0];
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] d_en, input logic [5:0] p0, p1, input logic [4:0] a0, a1,
                       input logic [1:0] wen, input logic [3:0] r0, input logic b0,
                       input logic [3:0] r1, input logic b1, input logic [1:0] wexc, input logic fl);
    bus.dispatch_en            = d_en;
    bus.dispatch_phys_rd[0]    = p0;
    bus.dispatch_phys_rd[1]    = p1;
    bus.dispatch_arch_rd[0]    = a0;
    bus.dispatch_arch_rd[1]    = a1;
    bus.writeback_en           = wen;
    bus.writeback_rob_addr[0]  = r0;
    bus.writeback_bank_addr[0] = b0;
    bus.writeback_rob_addr[1]  = r1;
    bus.writeback_bank_addr[1] = b1;
    bus.writeback_exc          = wexc;
    bus.flush                  = fl;
  endtask

  task automatic idle();
    drive(2'b00, 6'd0, 6'd0, 5'd0, 5'd0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dispatch_full"}, 32'(bus.dispatch_full), 0);
    chk({tag, " occupancy"}, 32'(bus.occupancy), 0);
    chk({tag, " commit_en"}, 32'(bus.commit_en), 0);
    chk({tag, " exc_valid"}, 32'(bus.exc_valid), 0);
    chk({tag, " rob_addr"}, 32'(bus.dispatch_rob_addr[0]), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // basic, out-of-order, single-lane, exceptions, flush, OR-merge, dispatch+commit
    vecs.push_back(v(3, 5, 6, 1, 2,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,0,0,0,1,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,1));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  3, 5, 6, 1, 2, 0,0,0, 1,1));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,1));
    vecs.push_back(v(3, 7, 8, 3, 4,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,1));
    vecs.push_back(v(3, 9,10, 5, 6,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,2));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,2,0,2,1,0,0,  0, 0, 0, 0, 0, 0,0,0, 2,3));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 2,3));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,1,0,1,1,0,0,  0, 0, 0, 0, 0, 0,0,0, 2,3));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  3, 7, 8, 3, 4, 0,0,0, 2,3));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  3, 9,10, 5, 6, 0,0,0, 1,3));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,3));
    vecs.push_back(v(1,11, 0, 7, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,3));
    vecs.push_back(v(0, 0, 0, 0, 0,   1,3,1,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,4));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,4));
    vecs.push_back(v(0, 0, 0, 0, 0,   2,0,0,3,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,4));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  1,11, 0, 7, 0, 0,0,0, 1,4));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,4));
    vecs.push_back(v(3,12,13, 8, 9,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,4));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,4,0,4,1,2,0,  0, 0, 0, 0, 0, 0,0,0, 1,5));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  1,12, 0, 8, 0, 1,1,4, 1,5));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(3,14,15,10,11,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,0,0,0,1,1,0,  0, 0, 0, 0, 0, 0,0,0, 1,1));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 1,0,0, 1,1));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(3,20,21,12,13,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,0,0,0,1,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,1));
    vecs.push_back(v(3,22,23,14,15,   0,0,0,0,0,0,1,  0, 0, 0, 0, 0, 0,0,0, 1,1));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(1,24, 0,16, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,0,0,0,0,2,0,  0, 0, 0, 0, 0, 0,0,0, 1,1));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 1,0,0, 1,1));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(3,25,26,17,18,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,0));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,0,0,0,1,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,1));
    vecs.push_back(v(3,27,28,19,20,   0,0,0,0,0,0,0,  3,25,26,17,18, 0,0,0, 1,1));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,2));
    vecs.push_back(v(0, 0, 0, 0, 0,   3,1,0,1,1,0,0,  0, 0, 0, 0, 0, 0,0,0, 1,2));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  3,27,28,19,20, 0,0,0, 1,2));
    vecs.push_back(v(0, 0, 0, 0, 0,   0,0,0,0,0,0,0,  0, 0, 0, 0, 0, 0,0,0, 0,2));

    repeat (3) @(posedge clk);
    to_sample();
    chk_reset_outputs("during_reset");
    next_cycle();
    rst = 1'b0;
    to_sample();
    chk_reset_outputs("after_reset");
    chk("bank_addr0", 32'(bus.dispatch_bank_addr[0]), 0);
    chk("bank_addr1", 32'(bus.dispatch_bank_addr[1]), 1);
    next_cycle();

    foreach (vecs[n]) begin
      vec_t t;
      string tag;
      t = vecs[n];
      tag = $sformatf("v%0d", n);
      drive(t.d_en, t.d_p0, t.d_p1, t.d_a0, t.d_a1, t.wb_en, t.wb_r0, t.wb_b0,
            t.wb_r1, t.wb_b1, t.wb_exc, t.fl);
      to_sample();
      chk({tag, " commit_en"}, 32'(bus.commit_en), 32'(t.e_ce));
      if (t.e_ce[0]) begin
        chk({tag, " commit_phys0"}, 32'(bus.commit_phys_rd[0]), 32'(t.e_p0));
        chk({tag, " commit_arch0"}, 32'(bus.commit_arch_rd[0]), 32'(t.e_a0));
      end
      if (t.e_ce[1]) begin
        chk({tag, " commit_phys1"}, 32'(bus.commit_phys_rd[1]), 32'(t.e_p1));
        chk({tag, " commit_arch1"}, 32'(bus.commit_arch_rd[1]), 32'(t.e_a1));
      end
      chk({tag, " exc_valid"}, 32'(bus.exc_valid), 32'(t.e_ex));
      if (t.e_ex) begin
        chk({tag, " exc_bank"}, 32'(bus.exc_bank_addr), 32'(t.e_exb));
        chk({tag, " exc_rob"}, 32'(bus.exc_rob_addr), 32'(t.e_exr));
      end
      chk({tag, " occupancy"}, 32'(bus.occupancy), 32'(t.e_occ));
      chk({tag, " rob_addr0"}, 32'(bus.dispatch_rob_addr[0]), 32'(t.e_tail));
      chk({tag, " rob_addr1"}, 32'(bus.dispatch_rob_addr[1]), 32'(t.e_tail));
      chk({tag, " full"}, 32'(bus.dispatch_full), 0);
      next_cycle();
    end

    // Fill to full, drop the 17th dispatch, then commit while dispatching.
    idle();
    rst = 1'b1;
    to_sample();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(2'b11, 6'(2*i), 6'(2*i+1), 5'(i), 5'(i), 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
      to_sample();
      chk($sformatf("fill%0d occupancy", i), 32'(bus.occupancy), 32'(i));
      chk($sformatf("fill%0d rob_addr", i), 32'(bus.dispatch_rob_addr[0]), 32'(i));
      chk($sformatf("fill%0d full", i), 32'(bus.dispatch_full), 0);
      next_cycle();
    end
    drive(2'b11, 6'd40, 6'd41, 5'd30, 5'd31, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
    to_sample();
    chk("full16 full", 32'(bus.dispatch_full), 1);
    chk("full16 occupancy", 32'(bus.occupancy), 16);
    chk("full16 rob_addr", 32'(bus.dispatch_rob_addr[0]), 0);
    next_cycle();
    drive(2'b00, 6'd0, 6'd0, 5'd0, 5'd0, 2'b11, 4'd0, 1'b0, 4'd0, 1'b1, 2'b00, 1'b0);
    to_sample();
    chk("drop17 occupancy", 32'(bus.occupancy), 16);
    chk("drop17 commit_en", 32'(bus.commit_en), 0);
    next_cycle();
    drive(2'b11, 6'd42, 6'd43, 5'd20, 5'd21, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
    to_sample();
    chk("commit_full commit_en", 32'(bus.commit_en), 3);
    chk("commit_full phys0", 32'(bus.commit_phys_rd[0]), 0);
    chk("commit_full phys1", 32'(bus.commit_phys_rd[1]), 1);
    chk("commit_full full", 32'(bus.dispatch_full), 1);
    next_cycle();
    idle();
    to_sample();
    chk("after_commit occupancy", 32'(bus.occupancy), 15);
    chk("after_commit full", 32'(bus.dispatch_full), 0);
    chk("after_commit rob_addr", 32'(bus.dispatch_rob_addr[0]), 0);
    next_cycle();
    drive(2'b11, 6'd44, 6'd45, 5'd22, 5'd23, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
    to_sample();
    next_cycle();
    idle();
    to_sample();
    chk("refill occupancy", 32'(bus.occupancy), 16);
    chk("refill full", 32'(bus.dispatch_full), 1);
    chk("refill rob_addr", 32'(bus.dispatch_rob_addr[0]), 1);
    next_cycle();

    // Reset while the head row is ready: nothing retires.
    drive(2'b00, 6'd0, 6'd0, 5'd0, 5'd0, 2'b11, 4'd1, 1'b0, 4'd1, 1'b1, 2'b00, 1'b0);
    to_sample();
    next_cycle();
    idle();
    rst = 1'b1;
    to_sample();
    chk("midrst commit_en", 32'(bus.commit_en), 0);
    chk("midrst exc_valid", 32'(bus.exc_valid), 0);
    next_cycle();
    rst = 1'b0;
    to_sample();
    chk_reset_outputs("post_midrst");
    next_cycle();
    to_sample();
    chk("post_midrst2 commit_en", 32'(bus.commit_en), 0);
    chk("post_midrst2 occupancy", 32'(bus.occupancy), 0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DISPATCH_WIDTH, default 2, sets the number of lanes/banks per ROB row (1..4).
REQ-002 Parameter ROB_DEPTH, default 16, sets the number of rows (power of 2, >=2); ROB_ADDR_WIDTH = clog2(ROB_DEPTH), DISPATCH_ADDR_WIDTH = max(1, clog2(DISPATCH_WIDTH)).
REQ-003 Parameter PHYS_REGS_ADDR_WIDTH, default 6, sets the physical register tag width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 dispatch_phys_rd / dispatch_arch_rd / dispatch_en  in  [DISPATCH_WIDTH] x PHYS_REGS_ADDR_WIDTH / 5 / 1  per-lane allocation request.
REQ-007 dispatch_bank_addr / dispatch_rob_addr  out  [DISPATCH_WIDTH] x DISPATCH_ADDR_WIDTH / ROB_ADDR_WIDTH  entry tag for each lane.
REQ-008 dispatch_full  out  1  no free row.
REQ-009 writeback_bank_addr / writeback_rob_addr / writeback_en / writeback_exc  in  [DISPATCH_WIDTH]  completion report per port, exc marks a faulting instruction.
REQ-010 commit_phys_rd / commit_arch_rd / commit_en  out  [DISPATCH_WIDTH]  retiring lanes of the head row.
REQ-011 exc_valid / exc_rob_addr / exc_bank_addr  out  1 / ROB_ADDR_WIDTH / DISPATCH_ADDR_WIDTH  precise-exception report.
REQ-012 flush  in  1  external pipeline flush.
REQ-013 occupancy  out  ROB_ADDR_WIDTH+1  number of allocated rows.

Function
REQ-014 Storage is ROB_DEPTH rows x DISPATCH_WIDTH slots; each slot holds valid, done, exc, phys_rd, arch_rd.
REQ-015 head and tail are ROB_ADDR_WIDTH-bit pointers wrapping modulo ROB_DEPTH; count (ROB_ADDR_WIDTH+1 bits) disambiguates full from empty.
REQ-016 dispatch_full = (count == ROB_DEPTH), from registered state only, never from same-cycle commit.
REQ-017 dispatch_rob_addr[i] = tail, dispatch_bank_addr[i] = i, combinational, for every lane regardless of en.
REQ-018 When any dispatch_en is set and not full and not flush, the row at tail is written (slot i valid = en[i], done = 0, exc = 0), tail increments, and count increments, all on the next edge.
REQ-019 Dispatch with dispatch_full = 1 is dropped with no state change.
REQ-020 A writeback with writeback_en[k] set on a valid slot sets done, and also sets exc when writeback_exc[k] is set; a writeback to an invalid slot is ignored.
REQ-021 Multiple writeback ports targeting the same slot in one cycle OR their effects.
REQ-022 A writeback to a row being allocated in the same cycle is a protocol violation; the behaviour is undefined.
REQ-023 The head row is retire-ready when the row is non-empty and every valid slot has done = 1.
REQ-024 With no exc in a ready head row: commit_en[i] = valid[i] and commit_phys_rd/arch_rd are driven from the slots, combinationally in the same cycle; head increments and count decrements at the edge.
REQ-025 With exc in a ready head row, at lowest faulting bank e: commit_en[i] = valid[i] for i < e only; exc_valid = 1 for one cycle with exc_rob_addr = head and exc_bank_addr = e; the whole ROB is cleared at the next edge (as flush).
REQ-026 Latency: a writeback at cycle t is visible as commit_en at cycle t+1 at the earliest; a dispatch at cycle t can be the head at t+1.
REQ-027 Dispatch and commit in the same cycle: count remains unchanged; a full ROB stays full for that cycle (dispatch blocked).
REQ-028 flush = 1: commit_en, exc_valid and dispatch acceptance are forced to 0 that cycle; next edge clears all valid bits and sets head = tail = count = 0.
REQ-029 flush has priority over dispatch, writeback, commit and the exception clear.
REQ-030 occupancy = count, registered.
REQ-031 When not enabled, commit and exception output data buses are don't-care, but the enables must be clean 0/1.

Reset
REQ-032 rst = 1 at an edge: all valid/done/exc bits cleared and head = tail = count = 0; rst has priority over flush and every other input.
REQ-033 During and immediately after reset: dispatch_full = 0, occupancy = 0, commit_en all 0, exc_valid = 0, dispatch_rob_addr = 0.
REQ-034 Reset asserted mid-operation discards all in-flight rows without committing any.

Verification
REQ-035 Reset, then dispatch 2 lanes (phys 5,6; arch 1,2) -> rob_addr 0, bank 0/1; writeback both next cycle -> commit_en = {1,1} with phys 5,6 one cycle later, occupancy back to 0.
REQ-036 Dispatch 16 rows with no writeback -> dispatch_full = 1, occupancy = 16; 17th dispatch dropped; commit row 0 while dispatching -> full persists that cycle, then tail wraps to 0.
REQ-037 Out-of-order writeback: row 1 done before row 0 -> no commit until row 0 done, then rows 0 and 1 retire on consecutive cycles.
REQ-038 Head row, bank 1 writeback_exc = 1 and bank 0 normal -> commit_en = {1,0}, exc_valid = 1, exc_bank_addr = 1, occupancy = 0 next cycle.
REQ-039 flush asserted alongside dispatch and a ready head -> no commit, no allocation, occupancy = 0 and tail = 0 next cycle.
REQ-040 Single-lane dispatch (en = {1,0}) -> commit_en = {1,0} only; a writeback to invalid bank 1 is ignored.
